// File: rtl/karatsuba_mul_sequencer_pkg.sv
// karatsuba_mul_sequencer_pkg: shared widths and one-hot state encoding for the multiplier sequencer
package karatsuba_mul_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = 4;
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CLEAR = 4'b0010,
    S_RUN   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;
endpackage

// File: rtl/karatsuba_mul_sequencer_if.sv
// karatsuba_mul_sequencer_if: operand input and product output valid/ready channels (master = producer/consumer side, slave = sequencer)
interface karatsuba_mul_sequencer_if
  import karatsuba_mul_sequencer_pkg::*;
#(
  parameter int W = DATA_W
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/karatsuba_mul_sequencer.sv
// karatsuba_mul_sequencer: accepts operands, runs the iterative multiplier for MUL_LAT cycles, holds the product in a valid/ready slot; ports: clk/rst, bus (slave), mul_* to/from multiplier, busy, op_count
module karatsuba_mul_sequencer
  import karatsuba_mul_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int W       = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  karatsuba_mul_sequencer_if.slave   bus,
  output logic                       mul_rst,
  output logic                       mul_enable,
  output logic [W-1:0]               mul_a,
  output logic [W-1:0]               mul_b,
  input  logic [2*W-1:0]             mul_c,
  output logic                       busy,
  output logic [15:0]                op_count
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             out_valid_q, out_valid_d;
  logic [2*W-1:0]   out_p_q, out_p_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             accept, fire, capture;
  assign accept  = bus.in_valid && state_q == S_IDLE;
  assign fire    = out_valid_q && bus.out_ready;
  // DONE may only overwrite the slot when it is empty or being drained this cycle
  assign capture = state_q == S_DONE && (!out_valid_q || bus.out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      op_count_q  <= op_count_d;
    end
  end
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = accept ? S_CLEAR : S_IDLE;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   state_d = cnt_q == '0 ? S_DONE : S_RUN;
      S_DONE:  state_d = capture ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cnt_d       = state_q == S_CLEAR ? CNT_W'(MUL_LAT - 1) :
                  state_q == S_RUN   ? cnt_q - CNT_W'(1) : cnt_q;
    mul_a_d     = accept ? bus.in_a : mul_a_q;
    mul_b_d     = accept ? bus.in_b : mul_b_q;
    out_valid_d = capture || (out_valid_q && !bus.out_ready);
    out_p_d     = capture ? mul_c : out_p_q;
    op_count_d  = op_count_q + 16'(fire);
  end
  always_comb begin
    bus.in_ready = state_q == S_IDLE;
    mul_rst      = rst || state_q == S_CLEAR;
    mul_enable   = state_q == S_RUN;
    busy         = state_q != S_IDLE;
  end
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign op_count      = op_count_q;
endmodule

// File: tb/tb_karatsuba_mul_sequencer.sv
// tb_karatsuba_mul_sequencer: directed scenarios against a cycle-exact behavioural multiplier partner
module tb_karatsuba_mul_sequencer;
  localparam int L = 5;
  logic        clk = 0;
  logic        rst = 1;
  logic        mul_rst, mul_enable, busy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_c;
  logic [15:0] op_count;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ecnt = 0;
  karatsuba_mul_sequencer_if #(.W(32)) bus ();
  karatsuba_mul_sequencer #(.MUL_LAT(L), .W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_rst(mul_rst), .mul_enable(mul_enable),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // multiplier stand-in: product is only valid after exactly L enabled cycles since clear
  always @(posedge clk) begin
    if (mul_rst) ecnt <= 0;
    else if (mul_enable) ecnt <= ecnt + 1;
  end
  assign mul_c = (ecnt == L) ? {32'd0, mul_a} * {32'd0, mul_b} : 64'hBAD0_BAD0_BAD0_BAD0;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b, output int t);
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < 100 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b exp 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 0;
    t = cyc;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
  endtask
  task automatic test_reset();
    rst = 1; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst_high: got %b exp 1", mul_rst); end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, mul_rst, mul_enable, bus.out_valid, busy} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b exp 10000", {bus.in_ready, mul_rst, mul_enable, bus.out_valid, busy});
    end
    checks++;
    if ({mul_a, mul_b, bus.out_p, op_count} !== 144'd0) begin
      errors++; $display("FAIL reset_data: a=%h b=%h p=%h cnt=%h exp 0", mul_a, mul_b, bus.out_p, op_count);
    end
  endtask
  task automatic test_single();
    int t, n;
    bus.out_ready = 1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    checks++;
    if ({mul_rst, mul_enable, busy, bus.in_ready} !== 4'b1010 || mul_a !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL single_clear: rst/en/busy/rdy=%b a=%h exp 1010 ffffffff", {mul_rst, mul_enable, busy, bus.in_ready}, mul_a);
    end
    wait_out(n);
    checks++;
    if (n !== L + 2) begin errors++; $display("FAIL single_latency: got %0d exp %0d", n, L + 2); end
    checks++;
    if (bus.out_p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL single_product: got %h exp fffffffe00000001", bus.out_p); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || op_count !== 16'd1) begin
      errors++; $display("FAIL single_consume: valid=%b cnt=%0d exp 0 1", bus.out_valid, op_count);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] av [3] = '{32'd3, 32'h1_0000, 32'd0};
    logic [31:0] bv [3] = '{32'd5, 32'h1_0000, 32'h1234};
    logic [63:0] pv [3] = '{64'd15, 64'h1_0000_0000, 64'd0};
    int t, tp, n;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(av[i], bv[i], t);
      if (i > 0) begin
        checks++;
        if (t - tp !== L + 3) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d exp %0d", i, t - tp, L + 3); end
      end
      tp = t;
      wait_out(n);
      checks++;
      if (bus.out_p !== pv[i]) begin errors++; $display("FAIL b2b_product_%0d: got %h exp %h", i, bus.out_p, pv[i]); end
    end
    @(negedge clk);
    checks++;
    if (op_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", op_count); end
  endtask
  task automatic test_backpressure();
    int t, n;
    bus.out_ready = 0;
    send(32'd2, 32'd3, t);
    wait_out(n);
    checks++;
    if (bus.out_p !== 64'd6) begin errors++; $display("FAIL bp_first: got %h exp 6", bus.out_p); end
    send(32'd4, 32'd5, t);
    repeat (12) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_p !== 64'd6 || busy !== 1'b1 || mul_enable !== 1'b0 || op_count !== 16'd4) begin
      errors++; $display("FAIL bp_stall: valid=%b p=%h busy=%b en=%b cnt=%0d exp 1 6 1 0 4", bus.out_valid, bus.out_p, busy, mul_enable, op_count);
    end
    bus.out_ready = 1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_p !== 64'd20 || op_count !== 16'd5) begin
      errors++; $display("FAIL bp_release: valid=%b p=%h cnt=%0d exp 1 14 5", bus.out_valid, bus.out_p, op_count);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || op_count !== 16'd6 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_drain: valid=%b cnt=%0d busy=%b exp 0 6 0", bus.out_valid, op_count, busy);
    end
  endtask
  task automatic test_same_cycle();
    int t, n;
    bus.out_ready = 0;
    send(32'd6, 32'd7, t);
    wait_out(n);
    send(32'd8, 32'd9, t);
    repeat (L + 1) @(negedge clk);
    checks++;
    if (bus.out_p !== 64'd42 || busy !== 1'b1 || mul_enable !== 1'b0 || mul_rst !== 1'b0) begin
      errors++; $display("FAIL sc_done_state: p=%h busy=%b en=%b rst=%b exp 2a 1 0 0", bus.out_p, busy, mul_enable, mul_rst);
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_p !== 64'd72 || op_count !== 16'd7 || busy !== 1'b0) begin
      errors++; $display("FAIL sc_swap: valid=%b p=%h cnt=%0d busy=%b exp 1 48 7 0", bus.out_valid, bus.out_p, op_count, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_p !== 64'd72 || op_count !== 16'd7) begin
      errors++; $display("FAIL sc_hold: valid=%b p=%h cnt=%0d exp 1 48 7", bus.out_valid, bus.out_p, op_count);
    end
    bus.out_ready = 1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || op_count !== 16'd8) begin
      errors++; $display("FAIL sc_drain: valid=%b cnt=%0d exp 0 8", bus.out_valid, op_count);
    end
  endtask
  task automatic test_reset_mid_run();
    int t, n;
    bus.out_ready = 1;
    send(32'd11, 32'd13, t);
    repeat (3) @(negedge clk);
    checks++;
    if (mul_enable !== 1'b1) begin errors++; $display("FAIL rr_in_run: en=%b exp 1", mul_enable); end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0 || mul_rst !== 1'b1) begin
      errors++; $display("FAIL rr_after_rst: rdy=%b valid=%b cnt=%0d busy=%b mrst=%b exp 1 0 0 0 1", bus.in_ready, bus.out_valid, op_count, busy, mul_rst);
    end
    rst = 0;
    @(negedge clk);
    send(32'd7, 32'd9, t);
    wait_out(n);
    checks++;
    if (n !== L + 2 || bus.out_p !== 64'd63) begin
      errors++; $display("FAIL rr_next_op: lat=%0d p=%h exp %0d 3f", n, bus.out_p, L + 2);
    end
    @(negedge clk);
  endtask
  task automatic test_wrap();
    int t, n;
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h exp ffff", op_count); end
    bus.out_ready = 1;
    send(32'd1, 32'd1, t);
    wait_out(n);
    @(negedge clk);
    checks++;
    if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_rollover: got %h exp 0000", op_count); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_same_cycle();
    test_reset_mid_run();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
